// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared 32-bit ALU.
// Shift-add multiply / restoring divide, one ALU step per cycle, 32 steps per operation.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  ALU_ADD = 4'b0000,
  parameter logic [3:0]  ALU_SUB = 4'b1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       ALU_Ctrl,
  input  logic [WIDTH-1:0] ALU_result
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_FIN  = 2'b10;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       op_r, op_nxt;
  // acc is hi (multiply) or rem (divide); lo is lo (multiply) or q (divide); opnd is b or d
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] lo, lo_nxt;
  logic [WIDTH-1:0] opnd, opnd_nxt;
  logic [WIDTH-1:0] result_nxt;

  logic [WIDTH-1:0] sh;
  logic             ge;
  logic             carry;
  logic             is_div;

  assign is_div = op_r[1];
  assign sh     = {acc[WIDTH-2:0], lo[WIDTH-1]};
  assign ge     = acc[WIDTH-1] | (sh >= opnd);
  assign carry  = (ALU_result < acc);

  assign busy    = (state == S_RUN);
  assign alu_req = busy;
  assign done    = (state == S_FIN);

  // ALU operand drive; kept apart from the next-state logic so ALU_result has no path back into it
  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    ALU_Ctrl = ALU_ADD;
    if (state == S_RUN) begin
      alu_src2 = opnd;
      if (is_div) begin
        alu_src1 = sh;
        ALU_Ctrl = ALU_SUB;
      end else begin
        alu_src1 = acc;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op_r;
    acc_nxt    = acc;
    lo_nxt     = lo;
    opnd_nxt   = opnd;
    result_nxt = result;
    case (state)
      S_IDLE, S_FIN: begin
        if (start) begin
          op_nxt   = op;
          cnt_nxt  = '0;
          acc_nxt  = '0;
          lo_nxt   = src_a;
          opnd_nxt = src_b;
          if (op[1] && (src_b == '0)) begin
            // divide by zero resolves immediately
            state_nxt  = S_FIN;
            result_nxt = op[0] ? src_a : '1;
          end else begin
            state_nxt = S_RUN;
          end
        end else if (state == S_FIN) begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (is_div) begin
          acc_nxt = ge ? ALU_result : sh;
          lo_nxt  = {lo[WIDTH-2:0], ge};
        end else if (lo[0]) begin
          acc_nxt = {carry, ALU_result[WIDTH-1:1]};
          lo_nxt  = {ALU_result[0], lo[WIDTH-1:1]};
        end else begin
          acc_nxt = {1'b0, acc[WIDTH-1:1]};
          lo_nxt  = {acc[0], lo[WIDTH-1:1]};
        end
        if (cnt == LAST_STEP) begin
          state_nxt  = S_FIN;
          result_nxt = op_r[0] ? acc_nxt : lo_nxt;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_r   <= '0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      op_r   <= op_nxt;
      acc    <= acc_nxt;
      lo     <= lo_nxt;
      opnd   <= opnd_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq with a behavioural ALU attached.
module tb_alu_muldiv_seq;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  ALU_Ctrl;
  logic [31:0] ALU_result;

  int tests_run;
  int tests_failed;

  alu_muldiv_seq #(.WIDTH(32), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result), .alu_req(alu_req),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .ALU_Ctrl(ALU_Ctrl), .ALU_result(ALU_result)
  );

  assign ALU_result = (ALU_Ctrl == ALU_SUB) ? (alu_src1 - alu_src2) : (alu_src1 + alu_src2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start during one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done from cycle 1; reports the cycle it appeared in and RUN cycles seen.
  task automatic wait_done(output int lat, output int nbusy, output int req_bad);
    lat = 1; nbusy = 0; req_bad = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) nbusy++;
      if (alu_req !== busy) req_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, nbusy, req_bad;
    issue(o, a, b);
    wait_done(lat, nbusy, req_bad);
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got cycle %0d, expected %0d", name, lat, exp_lat);
    end
    tests_run++;
    if (result !== exp) begin
      tests_failed++;
      $display("FAIL %s result: got %h, expected %h", name, result, exp);
    end
    tests_run++;
    if (nbusy !== exp_lat - 1 || req_bad !== 0) begin
      tests_failed++;
      $display("FAIL %s busy: got %0d busy cycles (%0d alu_req diffs), expected %0d", name, nbusy, req_bad, exp_lat - 1);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || result !== exp) begin
      tests_failed++;
      $display("FAIL %s after_done: got done=%b result=%h, expected done=0 result=%h", name, done, result, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || result !== 32'h0 ||
        alu_src1 !== 32'h0 || alu_src2 !== 32'h0 || ALU_Ctrl !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL %s: got busy=%b done=%b req=%b result=%h s1=%h s2=%h ctrl=%b, expected all zero/ADD",
               name, busy, done, alu_req, result, alu_src1, alu_src2, ALU_Ctrl);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    // first RUN cycle of 7*6: hi=0 + b=6 on ADD
    issue(2'b00, 32'd7, 32'd6);
    tests_run++;
    if (alu_src1 !== 32'h0 || alu_src2 !== 32'd6 || ALU_Ctrl !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL mul_alu_drive: got s1=%h s2=%h ctrl=%b, expected 0/6/ADD", alu_src1, alu_src2, ALU_Ctrl);
    end
    repeat (40) @(negedge clk);
    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 33);
    run_op("mulhu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
  endtask

  task automatic test_div();
    // first RUN cycle of 100/7: sh={0,q[31]=0}, d=7 on SUB
    issue(2'b10, 32'd100, 32'd7);
    tests_run++;
    if (alu_src1 !== 32'h0 || alu_src2 !== 32'd7 || ALU_Ctrl !== ALU_SUB) begin
      tests_failed++;
      $display("FAIL div_alu_drive: got s1=%h s2=%h ctrl=%b, expected 0/7/SUB", alu_src1, alu_src2, ALU_Ctrl);
    end
    repeat (40) @(negedge clk);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_max_1", 2'b10, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    run_op("remu_big", 2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);
  endtask

  task automatic test_div_zero();
    run_op("divu_9_0", 2'b10, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1);
  endtask

  task automatic test_back_to_back();
    int n;
    int lat, nbusy, req_bad;
    issue(2'b00, 32'd3, 32'd4);
    n = 1;
    while (n < 5) begin @(negedge clk); n++; end
    op = 2'b10; src_a = 32'd8; src_b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n++;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests_run++;
    if (n !== 33 || result !== 32'd12) begin
      tests_failed++;
      $display("FAIL ignore_start: got done cycle %0d result %0d, expected 33 and 12", n, result);
    end
    // restart during the FIN cycle
    op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL fin_restart: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    wait_done(lat, nbusy, req_bad);
    tests_run++;
    if (lat !== 33 || result !== 32'd25) begin
      tests_failed++;
      $display("FAIL fin_restart_result: got cycle %0d result %0d, expected 33 and 25", lat, result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int seen_done;
    issue(2'b10, 32'd1000, 32'd3);
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0) begin
      tests_failed++;
      $display("FAIL reset_abort: got %0d cycles with done/busy after reset, expected 0", seen_done);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
